// File: rtl/io_bus_arbiter_if.sv
//==============================================================================
// Module      : io_bus_arbiter_if
// Description : Wishbone, logic-analyser, device and interrupt bundle for the
//               io_bus_arbiter.
// Revision    : 1.0
//==============================================================================
`default_nettype none

interface io_bus_arbiter_if;
    // Wishbone classic slave side
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    // Logic-analyser requester
    logic        la_req_i;
    logic        la_we_i;
    logic [7:0]  la_adr_i;
    logic [31:0] la_dat_i;
    logic        la_ack_o;
    logic        la_err_o;
    logic [31:0] la_dat_o;

    // Shared device port
    logic        dev_req_o;
    logic        dev_we_o;
    logic [3:0]  dev_sel_o;
    logic [7:0]  dev_adr_o;
    logic [31:0] dev_dat_o;
    logic        dev_ack_i;
    logic [31:0] dev_dat_i;

    logic        irq_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        input  la_req_i, la_we_i, la_adr_i, la_dat_i,
        output la_ack_o, la_err_o, la_dat_o,
        output dev_req_o, dev_we_o, dev_sel_o, dev_adr_o, dev_dat_o,
        input  dev_ack_i, dev_dat_i,
        output irq_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        output la_req_i, la_we_i, la_adr_i, la_dat_i,
        input  la_ack_o, la_err_o, la_dat_o,
        input  dev_req_o, dev_we_o, dev_sel_o, dev_adr_o, dev_dat_o,
        output dev_ack_i, dev_dat_i,
        input  irq_o
    );
endinterface

`default_nettype wire

// File: rtl/io_bus_arbiter.sv
//==============================================================================
// Module      : io_bus_arbiter
// Description : Round-robin arbiter letting a Wishbone slave port and a
//               logic-analyser port share one device, with a per-transfer
//               timeout that returns 0xDEADBEEF and raises an interrupt.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module io_bus_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  wire             wb_clk_i,
    input  wire             wb_rst_i,
    io_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0]  c_last_cnt     = 8'(TIMEOUT - 1);
    localparam logic [31:0] c_timeout_data = 32'hDEAD_BEEF;

    state_t      state_q, state_d;
    logic        last_la_q, last_la_d;
    logic        la_req_q, la_req_d;
    logic        la_pend_q, la_pend_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        dev_req_q, dev_req_d;
    logic        dev_we_q, dev_we_d;
    logic [3:0]  dev_sel_q, dev_sel_d;
    logic [7:0]  dev_adr_q, dev_adr_d;
    logic [31:0] dev_dat_q, dev_dat_d;

    logic        wbs_ack_q, wbs_ack_d;
    logic [31:0] wbs_dat_q, wbs_dat_d;
    logic        la_ack_q, la_ack_d;
    logic        la_err_q, la_err_d;
    logic [31:0] la_dat_q, la_dat_d;
    logic        irq_q, irq_d;

    logic        w_wb_req;
    logic        w_la_rise;
    logic        w_la_in_flight;
    logic        w_grant_la;
    logic        w_finish;
    logic [31:0] w_resp_data;
    logic        w_unused_adr;

    assign w_wb_req       = bus.wbs_cyc_i & bus.wbs_stb_i &
                            (bus.wbs_adr_i[31:10] == BASE_ADDR[31:10]);
    assign w_la_rise      = bus.la_req_i & ~la_req_q;
    assign w_la_in_flight = (state_q != S_IDLE) & last_la_q;
    assign w_unused_adr   = ^bus.wbs_adr_i[1:0];

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q   <= S_IDLE;
            last_la_q <= 1'b1;
            la_req_q  <= 1'b0;
            la_pend_q <= 1'b0;
            cnt_q     <= '0;
            dev_req_q <= 1'b0;
            dev_we_q  <= 1'b0;
            dev_sel_q <= '0;
            dev_adr_q <= '0;
            dev_dat_q <= '0;
            wbs_ack_q <= 1'b0;
            wbs_dat_q <= '0;
            la_ack_q  <= 1'b0;
            la_err_q  <= 1'b0;
            la_dat_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_la_q <= last_la_d;
            la_req_q  <= la_req_d;
            la_pend_q <= la_pend_d;
            cnt_q     <= cnt_d;
            dev_req_q <= dev_req_d;
            dev_we_q  <= dev_we_d;
            dev_sel_q <= dev_sel_d;
            dev_adr_q <= dev_adr_d;
            dev_dat_q <= dev_dat_d;
            wbs_ack_q <= wbs_ack_d;
            wbs_dat_q <= wbs_dat_d;
            la_ack_q  <= la_ack_d;
            la_err_q  <= la_err_d;
            la_dat_q  <= la_dat_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_la_d   = last_la_q;
        la_req_d    = bus.la_req_i;
        la_pend_d   = la_pend_q;
        cnt_d       = cnt_q;
        dev_req_d   = dev_req_q;
        dev_we_d    = dev_we_q;
        dev_sel_d   = dev_sel_q;
        dev_adr_d   = dev_adr_q;
        dev_dat_d   = dev_dat_q;
        wbs_ack_d   = 1'b0;
        wbs_dat_d   = '0;
        la_ack_d    = 1'b0;
        la_err_d    = la_err_q;
        la_dat_d    = la_dat_q;
        irq_d       = 1'b0;
        w_grant_la  = 1'b0;
        w_finish    = 1'b0;
        w_resp_data = '0;

        // An LA edge is only remembered when nothing LA-related is outstanding.
        if (w_la_rise && !la_pend_q && !w_la_in_flight) begin
            la_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (w_wb_req || la_pend_q) begin
                    w_grant_la = la_pend_q && (!w_wb_req || !last_la_q);
                    last_la_d  = w_grant_la;
                    dev_req_d  = 1'b1;
                    state_d    = S_BUSY;
                    if (w_grant_la) begin
                        la_pend_d = 1'b0;
                        la_err_d  = 1'b0;
                        dev_we_d  = bus.la_we_i;
                        dev_sel_d = 4'hF;
                        dev_adr_d = bus.la_adr_i;
                        dev_dat_d = bus.la_dat_i;
                    end else begin
                        dev_we_d  = bus.wbs_we_i;
                        dev_sel_d = bus.wbs_sel_i;
                        dev_adr_d = bus.wbs_adr_i[9:2];
                        dev_dat_d = bus.wbs_dat_i;
                    end
                end
            end

            S_BUSY: begin
                cnt_d = cnt_q + 8'd1;
                // A device ack in the last allowed cycle beats the timeout.
                if (bus.dev_ack_i) begin
                    w_finish    = 1'b1;
                    w_resp_data = bus.dev_dat_i;
                end else if (cnt_q == c_last_cnt) begin
                    w_finish    = 1'b1;
                    w_resp_data = c_timeout_data;
                    irq_d       = 1'b1;
                    la_err_d    = last_la_q;
                end
                if (w_finish) begin
                    state_d   = S_RESP;
                    dev_req_d = 1'b0;
                    cnt_d     = '0;
                    if (last_la_q) begin
                        la_ack_d = 1'b1;
                        la_dat_d = w_resp_data;
                    end else begin
                        wbs_ack_d = 1'b1;
                        wbs_dat_d = w_resp_data;
                    end
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.wbs_ack_o = wbs_ack_q;
    assign bus.wbs_dat_o = wbs_dat_q;
    assign bus.la_ack_o  = la_ack_q;
    assign bus.la_err_o  = la_err_q;
    assign bus.la_dat_o  = la_dat_q;
    assign bus.dev_req_o = dev_req_q;
    assign bus.dev_we_o  = dev_we_q;
    assign bus.dev_sel_o = dev_sel_q;
    assign bus.dev_adr_o = dev_adr_q;
    assign bus.dev_dat_o = dev_dat_q;
    assign bus.irq_o     = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
//==============================================================================
// Module      : tb_io_bus_arbiter
// Description : Directed self-checking bench for io_bus_arbiter.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_io_bus_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    io_bus_arbiter_if bus ();

    io_bus_arbiter #(
        .BASE_ADDR (32'h3000_0000),
        .TIMEOUT   (16)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb_drive(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
    endtask

    task automatic wb_idle;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic dev_respond(input logic [31:0] dat);
        bus.dev_ack_i = 1'b1;
        bus.dev_dat_i = dat;
        tick();
        bus.dev_ack_i = 1'b0;
        bus.dev_dat_i = '0;
    endtask

    int n;
    int irq_seen;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        wb_idle();
        bus.wbs_sel_i = '0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        bus.la_req_i  = 1'b0;
        bus.la_we_i   = 1'b0;
        bus.la_adr_i  = '0;
        bus.la_dat_i  = '0;
        bus.dev_ack_i = 1'b0;
        bus.dev_dat_i = '0;

        // Reset state
        tick();
        tick();
        chk("rst_dev_req", 32'(bus.dev_req_o), 32'd0);
        chk("rst_wbs_ack", 32'(bus.wbs_ack_o), 32'd0);
        chk("rst_la_ack",  32'(bus.la_ack_o),  32'd0);
        chk("rst_la_err",  32'(bus.la_err_o),  32'd0);
        chk("rst_irq",     32'(bus.irq_o),     32'd0);
        chk("rst_la_dat",  bus.la_dat_o,       32'd0);
        rst_n = 1'b1;

        // WB write
        wb_drive(1'b1, 32'h3000_0010, 32'h1234_5678);
        tick();
        chk("wbw_dev_req", 32'(bus.dev_req_o), 32'd1);
        chk("wbw_dev_adr", 32'(bus.dev_adr_o), 32'h04);
        chk("wbw_dev_dat", bus.dev_dat_o,      32'h1234_5678);
        chk("wbw_dev_we",  32'(bus.dev_we_o),  32'd1);
        chk("wbw_dev_sel", 32'(bus.dev_sel_o), 32'hF);
        chk("wbw_no_ack_yet", 32'(bus.wbs_ack_o), 32'd0);
        dev_respond(32'h0);
        chk("wbw_ack",     32'(bus.wbs_ack_o), 32'd1);
        chk("wbw_req_low", 32'(bus.dev_req_o), 32'd0);
        chk("wbw_irq",     32'(bus.irq_o),     32'd0);
        wb_idle();
        tick();
        chk("wbw_ack_pulse", 32'(bus.wbs_ack_o), 32'd0);
        chk("wbw_no_regrant", 32'(bus.dev_req_o), 32'd0);

        // LA read at 0x20
        bus.la_we_i  = 1'b0;
        bus.la_adr_i = 8'h20;
        bus.la_req_i = 1'b1;
        tick();
        chk("lar_pend_cycle", 32'(bus.dev_req_o), 32'd0);
        tick();
        chk("lar_dev_req", 32'(bus.dev_req_o), 32'd1);
        chk("lar_dev_sel", 32'(bus.dev_sel_o), 32'hF);
        chk("lar_dev_adr", 32'(bus.dev_adr_o), 32'h20);
        chk("lar_dev_we",  32'(bus.dev_we_o),  32'd0);
        dev_respond(32'hCAFE_0001);
        chk("lar_ack",     32'(bus.la_ack_o),  32'd1);
        chk("lar_dat",     bus.la_dat_o,       32'hCAFE_0001);
        chk("lar_err",     32'(bus.la_err_o),  32'd0);
        chk("lar_no_wback", 32'(bus.wbs_ack_o), 32'd0);
        chk("lar_wbdat_zero", bus.wbs_dat_o,   32'd0);
        tick();
        chk("lar_ack_pulse", 32'(bus.la_ack_o), 32'd0);
        chk("lar_dat_hold", bus.la_dat_o,      32'hCAFE_0001);
        bus.la_req_i = 1'b0;

        // Arbitration: fresh reset so last grant is LA
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.la_adr_i = 8'h33;
        bus.la_req_i = 1'b1;
        tick();
        wb_drive(1'b0, 32'h3000_0020, 32'h0);
        tick();
        chk("arb1_wb_first", 32'(bus.dev_adr_o), 32'h08);
        chk("arb1_wb_sel",   32'(bus.dev_sel_o), 32'hF);
        dev_respond(32'hA5A5_0001);
        chk("arb1_wb_ack",   32'(bus.wbs_ack_o), 32'd1);
        chk("arb1_wb_dat",   bus.wbs_dat_o,      32'hA5A5_0001);
        wb_drive(1'b0, 32'h3000_0030, 32'h0);
        tick();
        chk("arb1_wbdat_cleared", bus.wbs_dat_o, 32'd0);
        tick();
        chk("arb2_la_first", 32'(bus.dev_adr_o), 32'h33);
        chk("arb2_la_req",   32'(bus.dev_req_o), 32'd1);
        dev_respond(32'h1111_2222);
        chk("arb2_la_ack",   32'(bus.la_ack_o),  32'd1);
        chk("arb2_la_dat",   bus.la_dat_o,       32'h1111_2222);
        tick();
        tick();
        chk("arb3_wb_next",  32'(bus.dev_adr_o), 32'h0C);
        dev_respond(32'h3333_4444);
        chk("arb3_wb_ack",   32'(bus.wbs_ack_o), 32'd1);
        chk("arb3_wb_dat",   bus.wbs_dat_o,      32'h3333_4444);
        wb_idle();
        bus.la_req_i = 1'b0;
        tick();
        tick();

        // LA timeout
        bus.la_adr_i = 8'h44;
        bus.la_req_i = 1'b1;
        tick();
        tick();
        n = 0;
        irq_seen = 0;
        while (bus.dev_req_o === 1'b1 && n < 40) begin
            n++;
            if (bus.irq_o === 1'b1) irq_seen++;
            tick();
        end
        chk("to_req_cycles", 32'(n),          32'd16);
        chk("to_irq_early",  32'(irq_seen),   32'd0);
        chk("to_irq",        32'(bus.irq_o),  32'd1);
        chk("to_la_ack",     32'(bus.la_ack_o), 32'd1);
        chk("to_la_dat",     bus.la_dat_o,    32'hDEAD_BEEF);
        chk("to_la_err",     32'(bus.la_err_o), 32'd1);
        tick();
        chk("to_irq_pulse",  32'(bus.irq_o),  32'd0);
        chk("to_err_sticky", 32'(bus.la_err_o), 32'd1);
        bus.la_req_i = 1'b0;
        tick();

        // Device ack in the last BUSY cycle
        bus.la_adr_i = 8'h55;
        bus.la_req_i = 1'b1;
        tick();
        tick();
        chk("late_req",      32'(bus.dev_req_o), 32'd1);
        chk("late_err_clr",  32'(bus.la_err_o),  32'd0);
        repeat (15) tick();
        chk("late_still_busy", 32'(bus.dev_req_o), 32'd1);
        dev_respond(32'hBEEF_0015);
        chk("late_ack",      32'(bus.la_ack_o),  32'd1);
        chk("late_dat",      bus.la_dat_o,       32'hBEEF_0015);
        chk("late_irq",      32'(bus.irq_o),     32'd0);
        chk("late_err",      32'(bus.la_err_o),  32'd0);
        bus.la_req_i = 1'b0;
        tick();

        // Reset during BUSY
        wb_drive(1'b1, 32'h3000_0040, 32'h7777_8888);
        tick();
        chk("mrst_busy",     32'(bus.dev_req_o), 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_req",      32'(bus.dev_req_o), 32'd0);
        chk("mrst_adr",      32'(bus.dev_adr_o), 32'd0);
        chk("mrst_dat",      bus.dev_dat_o,      32'd0);
        chk("mrst_la_dat",   bus.la_dat_o,       32'd0);
        wb_idle();
        rst_n = 1'b1;
        bus.dev_ack_i = 1'b1;
        tick();
        bus.dev_ack_i = 1'b0;
        chk("mrst_no_ack",   32'(bus.wbs_ack_o), 32'd0);
        chk("mrst_no_irq",   32'(bus.irq_o),     32'd0);

        // Out-of-window WB address plus stray device ack
        wb_drive(1'b0, 32'h3000_0400, 32'h0);
        bus.dev_ack_i = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.dev_req_o !== 1'b0 || bus.wbs_ack_o !== 1'b0) n++;
        end
        chk("oow_ignored",   32'(n), 32'd0);
        bus.dev_ack_i = 1'b0;
        wb_idle();
        tick();

        // WB request that drops while LA holds the device; LA re-edge in flight
        bus.la_adr_i = 8'h66;
        bus.la_req_i = 1'b1;
        tick();
        tick();
        chk("drop_la_busy",  32'(bus.dev_adr_o), 32'h66);
        wb_drive(1'b0, 32'h3000_0050, 32'h0);
        bus.la_req_i = 1'b0;
        tick();
        bus.la_req_i = 1'b1;
        tick();
        wb_idle();
        dev_respond(32'h0000_0066);
        chk("drop_la_ack",   32'(bus.la_ack_o),  32'd1);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.dev_req_o !== 1'b0 || bus.wbs_ack_o !== 1'b0 || bus.la_ack_o !== 1'b0) n++;
        end
        chk("drop_no_grant", 32'(n), 32'd0);
        bus.la_req_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
